// File: rtl/alu_pkg.sv
// Shared ALU definitions: select encodings, MOD engine state encoding, default width.
// Latency: none (definitions only).
// Backpressure: not applicable.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  // ALU select encodings; MOD is the one served by the multi-cycle engine.
  localparam logic [2:0] ALU_OP_ADD = 3'b000;
  localparam logic [2:0] ALU_OP_SUB = 3'b001;
  localparam logic [2:0] ALU_OP_AND = 3'b010;
  localparam logic [2:0] ALU_OP_OR  = 3'b011;
  localparam logic [2:0] ALU_OP_XOR = 3'b100;
  localparam logic [2:0] ALU_OP_SLL = 3'b101;
  localparam logic [2:0] ALU_OP_SRL = 3'b110;
  localparam logic [2:0] ALU_OP_MOD = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mod_state_t;

endpackage

// File: rtl/alu_mod_step.sv
// One restoring shift-compare-subtract step of unsigned division (module mod_step).
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
// Ports: rem (WIDTH+1 partial remainder), msb (next dividend bit), divisor,
//        rem_next (updated remainder), qbit (quotient bit produced by this step).
module mod_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic             msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic             qbit
);

  logic [WIDTH+1:0] shifted;

  // The full remainder is kept in the compare so no bit is silently dropped;
  // the top bit is always zero while the remainder stays below the divisor.
  assign shifted = {rem, msb};

  always_comb begin
    qbit     = (shifted >= {2'b00, divisor});
    rem_next = shifted[WIDTH:0];
    if (qbit) begin
      rem_next = shifted[WIDTH:0] - {1'b0, divisor};
    end
  end

endmodule

// File: rtl/alu_mod_unit.sv
// Multi-cycle unsigned remainder/quotient engine for the ALU MOD operation.
// Latency: WIDTH cycles from accepted start to done (1 cycle for b=0 when ALU_MOD_DIVZERO_EN).
// Backpressure: start is sampled only in IDLE/DONE; starts during RUN are dropped.
// Ports: clk, reset (sync, active-high), start, a, b -> result (a%b), quotient (a/b),
//        busy, sticky done, div_zero (only with ALU_MOD_DIVZERO_EN defined).
module alu_mod_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] quotient,
  output logic             busy,
`ifdef ALU_MOD_DIVZERO_EN
  output logic             div_zero,
`endif
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]       state;
  logic [WIDTH-1:0] dividend;   // shifts out dividend bits at the top, takes quotient bits at the bottom
  logic [WIDTH-1:0] divisor;
  logic [WIDTH:0]   rem;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   rem_next;
  logic             qbit;
  logic [WIDTH-1:0] div_next;

  mod_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .msb      (dividend[WIDTH-1]),
    .divisor  (divisor),
    .rem_next (rem_next),
    .qbit     (qbit)
  );

  // After WIDTH shifts the dividend register holds exactly the quotient.
  assign div_next = {dividend[WIDTH-2:0], qbit};

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      dividend <= '0;
      divisor  <= '0;
      rem      <= '0;
      count    <= '0;
      result   <= '0;
      quotient <= '0;
`ifdef ALU_MOD_DIVZERO_EN
      div_zero <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            dividend <= a;
            divisor  <= b;
            rem      <= '0;
            count    <= '0;
            state    <= ST_RUN;
`ifdef ALU_MOD_DIVZERO_EN
            div_zero <= 1'b0;
`endif
          end
        end
        ST_RUN: begin
`ifdef ALU_MOD_DIVZERO_EN
          // Zero divisor short-circuits on the first RUN cycle; the dividend is still unshifted.
          if (divisor == '0) begin
            result   <= dividend;
            quotient <= '1;
            div_zero <= 1'b1;
            state    <= ST_DONE;
          end else
`endif
          begin
            dividend <= div_next;
            rem      <= rem_next;
            count    <= count + CW'(1);
            if (count == LAST) begin
              result   <= rem_next[WIDTH-1:0];
              quotient <= div_next;
              state    <= ST_DONE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

endmodule
